// File: rtl/mem_map_pkg.sv
// mem_map_pkg: region codes, default region sizes and controller states for mem_region_ctrl.
package mem_map_pkg;
  typedef enum logic [2:0] {
    R_TEXT   = 3'd0,
    R_GLYPH  = 3'd1,
    R_INPUT  = 3'd2,
    R_OUTPUT = 3'd3,
    R_INSTR  = 3'd4,
    R_STACK  = 3'd5,
    R_NONE   = 3'd7
  } region_t;
  localparam int DEF_SIZE_TEXT   = 8192;
  localparam int DEF_SIZE_GLYPH  = 1024;
  localparam int DEF_SIZE_INPUT  = 128;
  localparam int DEF_SIZE_OUTPUT = 128;
  localparam int DEF_SIZE_INSTR  = 10240;
  localparam int DEF_SIZE_STACK  = 10240;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps an address onto the cumulative six-region map, giving region code and offset.
module mem_region_decode
  import mem_map_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int OFF_W      = ADDR_W,
  parameter int SIZE_TEXT  = DEF_SIZE_TEXT,
  parameter int SIZE_GLYPH = DEF_SIZE_GLYPH,
  parameter int SIZE_INPUT = DEF_SIZE_INPUT,
  parameter int SIZE_OUTPUT = DEF_SIZE_OUTPUT,
  parameter int SIZE_INSTR = DEF_SIZE_INSTR,
  parameter int SIZE_STACK = DEF_SIZE_STACK
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [OFF_W-1:0]  offset
);
  localparam logic [31:0] B_GLYPH  = 32'(SIZE_TEXT);
  localparam logic [31:0] B_INPUT  = B_GLYPH + 32'(SIZE_GLYPH);
  localparam logic [31:0] B_OUTPUT = B_INPUT + 32'(SIZE_INPUT);
  localparam logic [31:0] B_INSTR  = B_OUTPUT + 32'(SIZE_OUTPUT);
  localparam logic [31:0] B_STACK  = B_INSTR + 32'(SIZE_INSTR);
  localparam logic [31:0] MAP_END  = B_STACK + 32'(SIZE_STACK);
  logic [31:0] a;
  logic [31:0] base;
  always_comb begin
    a = 32'(addr);
    region = R_NONE;
    base = a;
    if (a < B_GLYPH) begin
      region = R_TEXT;
      base = 32'd0;
    end else if (a < B_INPUT) begin
      region = R_GLYPH;
      base = B_GLYPH;
    end else if (a < B_OUTPUT) begin
      region = R_INPUT;
      base = B_INPUT;
    end else if (a < B_INSTR) begin
      region = R_OUTPUT;
      base = B_OUTPUT;
    end else if (a < B_STACK) begin
      region = R_INSTR;
      base = B_INSTR;
    end else if (a < MAP_END) begin
      region = R_STACK;
      base = B_STACK;
    end
    offset = OFF_W'(a - base);
  end
endmodule

// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: arbitrates CPU and video ports onto one synchronous RAM with region decode and faults.
// Optional MEMCTRL_WP_EN enables write protection of the instruction region via wp_lock.
module mem_region_ctrl
  import mem_map_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int SIZE_TEXT  = DEF_SIZE_TEXT,
  parameter int SIZE_GLYPH = DEF_SIZE_GLYPH,
  parameter int SIZE_INPUT = DEF_SIZE_INPUT,
  parameter int SIZE_OUTPUT = DEF_SIZE_OUTPUT,
  parameter int SIZE_INSTR = DEF_SIZE_INSTR,
  parameter int SIZE_STACK = DEF_SIZE_STACK
) (
  input  logic              ext_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_fault,
  output logic [2:0]        cpu_region,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              wp_lock,
  output logic              out_wr,
  output logic [6:0]        out_idx,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_nx;
  logic port_vid, cpu_last, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cpu_rdata_q, vid_rdata_q;
  region_t region, cpu_region_q;
  logic [6:0] offset;
  logic accept, grant_vid, issue, resp, fault, done;

  mem_region_decode #(
    .ADDR_W(ADDR_W), .OFF_W(7),
    .SIZE_TEXT(SIZE_TEXT), .SIZE_GLYPH(SIZE_GLYPH), .SIZE_INPUT(SIZE_INPUT),
    .SIZE_OUTPUT(SIZE_OUTPUT), .SIZE_INSTR(SIZE_INSTR), .SIZE_STACK(SIZE_STACK)
  ) u_decode (
    .addr(addr_q),
    .region(region),
    .offset(offset)
  );

`ifdef MEMCTRL_WP_EN
  assign fault = (region == R_NONE) || (!port_vid && we_q && wp_lock && region == R_INSTR);
`else
  logic unused_wp;
  assign unused_wp = wp_lock;
  assign fault = region == R_NONE;
`endif

  // Video wins unless the CPU also requests and video was granted last.
  assign grant_vid = vid_req && (!cpu_req || cpu_last);
  assign accept = state == S_IDLE && (cpu_req || vid_req);

  always_comb begin
    issue = state == S_ISSUE;
    resp = state == S_RESP;
    state_nx = accept ? S_ISSUE : (issue && !fault && !we_q) ? S_RESP : S_IDLE;
    done = (issue && (fault || we_q)) || resp;
    cpu_ack = done && !port_vid;
    vid_ack = done && port_vid;
    cpu_fault = cpu_ack && issue && fault;
    cpu_rdata = cpu_ack ? (resp ? mem_rdata : '0) : cpu_rdata_q;
    vid_rdata = vid_ack ? (resp ? mem_rdata : '0) : vid_rdata_q;
    cpu_region = (state != S_IDLE && !port_vid) ? region : cpu_region_q;
    mem_en = issue && !fault;
    mem_we = mem_en && we_q;
    mem_addr = mem_en ? addr_q : '0;
    mem_wdata = mem_we ? wdata_q : '0;
    out_wr = mem_we && region == R_OUTPUT;
    out_idx = out_wr ? offset : 7'd0;
  end

  always_ff @(posedge ext_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      port_vid <= 1'b0;
      cpu_last <= 1'b1;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_region_q <= R_NONE;
    end else begin
      state <= state_nx;
      if (accept) begin
        port_vid <= grant_vid;
        cpu_last <= !grant_vid;
        we_q <= !grant_vid && cpu_we;
        addr_q <= grant_vid ? vid_addr : cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (cpu_ack && !we_q) cpu_rdata_q <= cpu_rdata;
      if (vid_ack) vid_rdata_q <= vid_rdata;
      if (issue && !port_vid) cpu_region_q <= region;
    end
  end
endmodule

// File: tb/tb_mem_region_ctrl.sv
// tb_mem_region_ctrl: randomized self-checking bench for mem_region_ctrl against a region-map reference model.
module tb_mem_region_ctrl;
  logic ext_clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0, wp_lock = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, vid_addr = '0;
  logic cpu_ack, cpu_fault, vid_ack, out_wr, mem_en, mem_we;
  logic [15:0] cpu_rdata, vid_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [2:0] cpu_region;
  logic [6:0] out_idx;

  always #5 ext_clk = ~ext_clk;

  mem_region_ctrl dut (
    .ext_clk(ext_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault), .cpu_region(cpu_region),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .wp_lock(wp_lock), .out_wr(out_wr), .out_idx(out_idx),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [15:0] ram [0:65535];
  logic [15:0] model [0:65535];
  always @(posedge ext_clk) if (mem_en) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int total = 0, pass = 0;
  int lat;
  logic r_f, saw_en, saw_we, saw_ow;
  logic [15:0] r_rd;
  logic [2:0] r_rg;
  logic [6:0] ow_i;

  function automatic int ref_base(logic [15:0] a);
    int sizes[6] = '{8192, 1024, 128, 128, 10240, 10240};
    int base = 0;
    for (int i = 0; i < 6; i++) begin
      if (int'(a) < base + sizes[i]) return base;
      base += sizes[i];
    end
    return int'(a);
  endfunction

  function automatic logic [2:0] ref_region(logic [15:0] a);
    int sizes[6] = '{8192, 1024, 128, 128, 10240, 10240};
    int base = 0;
    for (int i = 0; i < 6; i++) begin
      if (int'(a) < base + sizes[i]) return 3'(i);
      base += sizes[i];
    end
    return 3'd7;
  endfunction

  function automatic logic ref_fault(logic [2:0] r, logic we, logic wp);
`ifdef MEMCTRL_WP_EN
    return r == 3'd7 || (we && wp && r == 3'd4);
`else
    return r == 3'd7 || (we && wp && 1'b0);
`endif
  endfunction

  task automatic do_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
    @(posedge ext_clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0; saw_en = 0; saw_we = 0; saw_ow = 0; ow_i = 0;
    while (lat < 20) begin
      @(posedge ext_clk); #1;
      lat++;
      if (lat == 1) cpu_addr = 16'($urandom);
      saw_en |= mem_en;
      saw_we |= mem_we;
      if (out_wr) begin saw_ow = 1'b1; ow_i = out_idx; end
      if (cpu_ack) break;
    end
    r_f = cpu_fault; r_rd = cpu_rdata; r_rg = cpu_region;
    cpu_req = 1'b0;
  endtask

  task automatic do_vid(input logic [15:0] a);
    @(posedge ext_clk); #1;
    vid_req = 1'b1; vid_addr = a; lat = 0;
    while (lat < 20) begin
      @(posedge ext_clk); #1;
      lat++;
      if (lat == 1) vid_addr = 16'($urandom);
      if (vid_ack) break;
    end
    r_rd = vid_rdata;
    vid_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge ext_clk);
    #1;
    total++;
    if ({cpu_ack, vid_ack, cpu_fault, mem_en, mem_we, out_wr} !== 6'b0) $display("FAIL reset_strobes got=%b want=000000", {cpu_ack, vid_ack, cpu_fault, mem_en, mem_we, out_wr});
    else pass++;
    total++;
    if (cpu_region !== 3'd7) $display("FAIL reset_region got=%0d want=7", cpu_region);
    else pass++;
    total++;
    if ({mem_addr, mem_wdata, out_idx} !== 39'b0) $display("FAIL reset_buses got=%h want=0", {mem_addr, mem_wdata, out_idx});
    else pass++;
    @(negedge ext_clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_rw();
    do_cpu(1'b1, 16'h0010, 16'hBEEF);
    model[16'h0010] = 16'hBEEF;
    total++;
    if ({8'(lat), saw_we, r_f} !== {8'd1, 1'b1, 1'b0}) $display("FAIL write_ack got lat=%0d we=%b fault=%b want lat=1 we=1 fault=0", lat, saw_we, r_f);
    else pass++;
    do_cpu(1'b0, 16'h0010, 16'h0);
    total++;
    if ({8'(lat), r_rd, r_rg} !== {8'd2, 16'hBEEF, 3'd0}) $display("FAIL read_back got lat=%0d data=%h region=%0d want lat=2 data=beef region=0", lat, r_rd, r_rg);
    else pass++;
  endtask

  task automatic test_output_strobe();
    do_cpu(1'b1, 16'h2485, 16'h1234);
    model[16'h2485] = 16'h1234;
    total++;
    if ({saw_ow, ow_i, r_rg, 8'(lat)} !== {1'b1, 7'd5, 3'd3, 8'd1}) $display("FAIL out_wr got ow=%b idx=%0d region=%0d lat=%0d want ow=1 idx=5 region=3 lat=1", saw_ow, ow_i, r_rg, lat);
    else pass++;
  endtask

  task automatic test_unmapped();
    do_cpu(1'b0, 16'h7500, 16'h0);
    total++;
    if ({8'(lat), r_f, saw_en, r_rd, r_rg} !== {8'd1, 1'b1, 1'b0, 16'h0, 3'd7}) $display("FAIL unmapped got lat=%0d fault=%b en=%b data=%h region=%0d want lat=1 fault=1 en=0 data=0 region=7", lat, r_f, saw_en, r_rd, r_rg);
    else pass++;
    do_cpu(1'b1, 16'hFFFF, 16'h5555);
    total++;
    if ({r_f, saw_en} !== 2'b10) $display("FAIL unmapped_wr got fault=%b en=%b want fault=1 en=0", r_f, saw_en);
    else pass++;
  endtask

  task automatic test_write_protect();
    logic ef;
    wp_lock = 1'b1;
    ef = ref_fault(3'd4, 1'b1, 1'b1);
    do_cpu(1'b1, 16'h2600, 16'h5A5A);
    wp_lock = 1'b0;
    if (!ef) model[16'h2600] = 16'h5A5A;
    total++;
    if ({r_f, saw_we, r_rg} !== {ef, !ef, 3'd4}) $display("FAIL wp_write got fault=%b we=%b region=%0d want fault=%b we=%b region=4", r_f, saw_we, r_rg, ef, !ef);
    else pass++;
    do_cpu(1'b0, 16'h2600, 16'h0);
    total++;
    if (r_rd !== model[16'h2600]) $display("FAIL wp_readback got=%h want=%h", r_rd, model[16'h2600]);
    else pass++;
  endtask

  task automatic test_random();
    logic [15:0] pool[16] = '{16'h0000, 16'h1FFF, 16'h2000, 16'h23FF, 16'h2400, 16'h247F, 16'h2480, 16'h24FF,
                              16'h2500, 16'h4CFF, 16'h4D00, 16'h74FF, 16'h7500, 16'hFFFF, 16'h0123, 16'h6000};
    for (int n = 0; n < 120; n++) begin
      logic [15:0] a, d;
      logic we, wp, ef;
      logic [2:0] er;
      int el;
      a = ($urandom % 3 == 0) ? 16'($urandom) : pool[$urandom % 16];
      d = 16'($urandom);
      if ($urandom % 4 == 0) begin
        er = ref_region(a);
        do_vid(a);
        total++;
        if ({8'(lat), r_rd} !== {er == 3'd7 ? 8'd1 : 8'd2, er == 3'd7 ? 16'h0 : model[a]}) $display("FAIL rand_vid[%0d] a=%h got lat=%0d data=%h want data=%h", n, a, lat, r_rd, er == 3'd7 ? 16'h0 : model[a]);
        else pass++;
      end else begin
        we = 1'($urandom);
        wp = 1'($urandom);
        er = ref_region(a);
        ef = ref_fault(er, we, wp);
        el = (ef || we) ? 1 : 2;
        wp_lock = wp;
        do_cpu(we, a, d);
        wp_lock = 1'b0;
        total++;
        if ({8'(lat), r_f, r_rg} !== {8'(el), ef, er}) $display("FAIL rand_cpu[%0d] a=%h we=%b got lat=%0d fault=%b region=%0d want lat=%0d fault=%b region=%0d", n, a, we, lat, r_f, r_rg, el, ef, er);
        else pass++;
        total++;
        if (we) begin
          if ({saw_we, saw_ow, ow_i} !== {!ef, !ef && er == 3'd3, (!ef && er == 3'd3) ? 7'(int'(a) - ref_base(a)) : 7'd0})
            $display("FAIL rand_wr[%0d] a=%h got we=%b ow=%b idx=%0d want we=%b", n, a, saw_we, saw_ow, ow_i, !ef);
          else pass++;
          if (!ef) model[a] = d;
        end else begin
          if (r_rd !== (ef ? 16'h0 : model[a])) $display("FAIL rand_rd[%0d] a=%h got=%h want=%h", n, a, r_rd, ef ? 16'h0 : model[a]);
          else pass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int cyc = 0;
    reset = 1'b0;
    @(posedge ext_clk);
    @(negedge ext_clk);
    reset = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h0010; vid_addr = 16'h2485;
    cpu_req = 1'b1; vid_req = 1'b1;
    while (acks < 6 && cyc < 60) begin
      @(posedge ext_clk); #1;
      cyc++;
      if (cpu_ack || vid_ack) begin
        total++;
        if ({vid_ack, cpu_ack} !== ((acks % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL rr_order[%0d] got vid=%b cpu=%b want vid=%b", acks, vid_ack, cpu_ack, acks % 2 == 0);
        else pass++;
        total++;
        if ((vid_ack ? vid_rdata : cpu_rdata) !== (vid_ack ? model[16'h2485] : model[16'h0010])) $display("FAIL rr_data[%0d] got=%h", acks, vid_ack ? vid_rdata : cpu_rdata);
        else pass++;
        acks++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    total++;
    if (acks != 6) $display("FAIL rr_timeout got=%0d acks want=6", acks);
    else pass++;
    repeat (4) @(posedge ext_clk);
  endtask

  task automatic test_reset_in_resp();
    logic seen = 1'b0;
    @(posedge ext_clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2485;
    @(posedge ext_clk);
    @(posedge ext_clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    total++;
    if ({cpu_ack, mem_en, cpu_fault, cpu_region} !== {3'b000, 3'd7}) $display("FAIL rst_resp got ack=%b en=%b fault=%b region=%0d want 0 0 0 7", cpu_ack, mem_en, cpu_fault, cpu_region);
    else pass++;
    repeat (3) begin
      @(posedge ext_clk); #1;
      seen |= cpu_ack;
    end
    @(negedge ext_clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge ext_clk); #1;
      seen |= cpu_ack;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rst_dropped got ack=%b want=0", seen);
    else pass++;
    do_cpu(1'b0, 16'h2485, 16'h0);
    total++;
    if ({8'(lat), r_rd, r_rg} !== {8'd2, model[16'h2485], 3'd3}) $display("FAIL rst_recover got lat=%0d data=%h region=%0d want lat=2 data=%h region=3", lat, r_rd, r_rg, model[16'h2485]);
    else pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'h0;
      model[i] = 16'h0;
    end
    test_reset();
    test_basic_rw();
    test_output_strobe();
    test_unmapped();
    test_write_protect();
    test_random();
    test_back_to_back();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
